// File: rtl/fmul_result_fifo.sv
// fmul_result_fifo: first-word-fall-through queue for multiplier results with sticky overflow status.
// Optional macro FMUL_FTZ_EN flushes subnormal products to signed zero and adds sticky_unf.
module fmul_result_fifo #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 5
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [31:0]                in_y,
   input  logic                       in_ovf,
   input  logic [TAG_W-1:0]           in_tag,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_y,
   output logic                       out_ovf,
   output logic [TAG_W-1:0]           out_tag,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       sticky_ovf,
`ifdef FMUL_FTZ_EN
   output logic                       sticky_unf,
`endif
   input  logic                       clr_sticky
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int EW = 33 + TAG_W;
   logic [EW-1:0] mem [DEPTH];
   logic [EW-1:0] head;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [31:0]   wy;
   logic          push, pop;
   assign in_ready  = count != CW'(DEPTH);
   assign out_valid = count != '0;
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
`ifdef FMUL_FTZ_EN
   logic sub;
   assign sub = (in_y[30:23] == 8'd0) && (in_y[22:0] != 23'd0);
   assign wy  = sub ? {in_y[31], 31'd0} : in_y;
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) sticky_unf <= 1'b0;
      else       sticky_unf <= (push & sub) | (sticky_unf & ~clr_sticky);
`else
   assign wy = in_y;
`endif
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= {in_tag, in_ovf, wy};
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         sticky_ovf <= 1'b0;
      end else begin
         wr_ptr     <= push ? wr_ptr + PW'(1) : wr_ptr;
         rd_ptr     <= pop ? rd_ptr + PW'(1) : rd_ptr;
         count      <= count + CW'(push) - CW'(pop);
         sticky_ovf <= (push & in_ovf) | (sticky_ovf & ~clr_sticky);
      end
   // outputs read as zero while empty so reset leaves no stale data visible
   assign head    = out_valid ? mem[rd_ptr] : '0;
   assign out_y   = head[31:0];
   assign out_ovf = head[32];
   assign out_tag = head[EW-1:33];
endmodule
